// File: rtl/input_unit_pkg.sv
// Shared types and default sizing for the core's input port unit.
package input_unit_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned DEPTH_DEF  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

endpackage

// File: rtl/input_fifo.sv
// Synchronous-write, combinational-read byte buffer for the input port.
module input_fifo
    import input_unit_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic              do_push;
    logic              do_pop;

    // Full/empty come from the pre-edge count, so a push into a full buffer
    // waits a cycle even if a pop is happening alongside it.
    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = empty ? '0 : mem[rd_ptr];
    assign count    = count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/input_unit.sv
// Input port unit: strobe synchroniser, 4-phase handshake FSM and byte FIFO
// feeding IN instructions in EX.
module input_unit
    import input_unit_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned DEPTH       = DEPTH_DEF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        in_port,
    input  logic                     in_strobe,
    output logic                     in_ack,
    input  logic                     id_ex_input_en,
    output logic [DATA_W-1:0]        in_data,
    output logic                     in_stall,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     fifo_full
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   strobe_s;
    state_t                 state_q;
    state_t                 state_d;
    logic                   ack_q;
    logic                   ack_d;
    logic                   push_c;
    logic                   fifo_empty;

    // Metastability chain on the asynchronous strobe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_strobe};
        end
    end

    assign strobe_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
        end
    end

    // One capture per strobe pulse; a full buffer leaves the device waiting
    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        push_c  = 1'b0;
        case (state_q)
            IDLE: begin
                ack_d = 1'b0;
                if (strobe_s && !fifo_full) begin
                    push_c  = 1'b1;
                    ack_d   = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                ack_d = 1'b1;
                if (!strobe_s) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                ack_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign in_ack   = ack_q;
    assign in_stall = id_ex_input_en && fifo_empty;

    input_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_c),
        .push_data (in_port),
        .pop       (id_ex_input_en),
        .pop_data  (in_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_input_unit.sv
// Directed bench for input_unit: queue-based reference model checked every
// cycle, plus literal expectations for handshake timing and byte order.
module tb_input_unit;

    localparam int unsigned DATA_W      = 8;
    localparam int unsigned DEPTH       = 4;
    localparam int unsigned SYNC_STAGES = 2;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic [DATA_W-1:0]      in_port = '0;
    logic                   in_strobe = 1'b0;
    logic                   in_ack;
    logic                   id_ex_input_en = 1'b0;
    logic [DATA_W-1:0]      in_data;
    logic                   in_stall;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   fifo_full;

    int vectors = 0;
    int miscompares = 0;

    input_unit #(
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_port        (in_port),
        .in_strobe      (in_strobe),
        .in_ack         (in_ack),
        .id_ex_input_en (id_ex_input_en),
        .in_data        (in_data),
        .in_stall       (in_stall),
        .fifo_count     (fifo_count),
        .fifo_full      (fifo_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: byte queue, strobe seen SYNC_STAGES edges late,
    // one acceptance per pulse, full/empty decided on pre-edge occupancy.
    logic [DATA_W-1:0] mq[$];
    bit                sh[$];
    bit                m_ack = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            sh.delete();
            for (int i = 0; i < int'(SYNC_STAGES); i++) sh.push_back(1'b0);
            m_ack = 1'b0;
        end else begin
            bit s;
            int pre;
            s = sh.pop_front();
            sh.push_back(in_strobe);
            pre = mq.size();
            if (id_ex_input_en && pre > 0) void'(mq.pop_front());
            if (!m_ack) begin
                if (s && pre < int'(DEPTH)) begin
                    mq.push_back(in_port);
                    m_ack = 1'b1;
                end
            end else if (!s) begin
                m_ack = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        int sz;
        sz = mq.size();
        chk("ack",   int'(in_ack),     int'(m_ack));
        chk("count", int'(fifo_count), sz);
        chk("full",  int'(fifo_full),  int'(sz == int'(DEPTH)));
        chk("stall", int'(in_stall),   int'(id_ex_input_en && sz == 0));
        chk("data",  int'(in_data),    sz > 0 ? int'(mq[0]) : 0);
    end

    // Inputs change 2 time units after the rising edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ack(input logic val, input int max, input string name);
        int n = 0;
        while (in_ack !== val && n < max) begin
            tick();
            n++;
        end
        chk(name, int'(in_ack), int'(val));
    endtask

    task automatic send_byte(input logic [DATA_W-1:0] b);
        in_port   = b;
        in_strobe = 1'b1;
        wait_ack(1'b1, 10, "send_ack_rise");
        in_strobe = 1'b0;
        wait_ack(1'b0, 10, "send_ack_fall");
    endtask

    task automatic pop_check(input logic [DATA_W-1:0] exp, input string name);
        id_ex_input_en = 1'b1;
        #1;
        chk(name, int'(in_data), int'(exp));
        chk("pop_stall", int'(in_stall), 0);
        tick();
        id_ex_input_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) tick();
        rst = 1'b1;
        tick();

        // Single transfer: ack rises exactly 2 edges after first sample
        in_port   = 8'hA5;
        in_strobe = 1'b1;
        tick(); chk("single_ack_e0", int'(in_ack), 0);
        tick(); chk("single_ack_e1", int'(in_ack), 0);
        tick(); chk("single_ack_e2", int'(in_ack), 1);
        chk("single_cnt1", int'(fifo_count), 1);
        in_strobe = 1'b0;
        wait_ack(1'b0, 10, "single_ack_fall");
        pop_check(8'hA5, "single_data");
        chk("single_cnt0", int'(fifo_count), 0);

        // Fill to full, 5th byte blocked until one pop
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        chk("fill_full", int'(fifo_full), 1);
        chk("fill_cnt4", int'(fifo_count), 4);
        in_port   = 8'h55;
        in_strobe = 1'b1;
        repeat (8) tick();
        chk("blocked_ack", int'(in_ack), 0);
        pop_check(8'h11, "order_11");
        wait_ack(1'b1, 6, "late_ack_rise");
        in_strobe = 1'b0;
        wait_ack(1'b0, 6, "late_ack_fall");
        pop_check(8'h22, "order_22");
        pop_check(8'h33, "order_33");
        pop_check(8'h44, "order_44");
        pop_check(8'h55, "order_55");
        chk("drain_cnt0", int'(fifo_count), 0);

        // Reset mid-handshake discards buffered data and drops ack at once
        send_byte(8'h77);
        in_port   = 8'h78;
        in_strobe = 1'b1;
        wait_ack(1'b1, 10, "pre_rst_ack");
        rst = 1'b0;
        #1;
        chk("rst_ack", int'(in_ack), 0);
        chk("rst_cnt", int'(fifo_count), 0);
        chk("rst_stall", int'(in_stall), 0);
        chk("rst_data", int'(in_data), 0);
        in_strobe = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();

        // IN with empty buffer stalls until a byte arrives
        id_ex_input_en = 1'b1;
        #1;
        chk("empty_stall", int'(in_stall), 1);
        tick();
        chk("empty_cnt", int'(fifo_count), 0);
        in_port   = 8'h3C;
        in_strobe = 1'b1;
        wait_ack(1'b1, 10, "empty_ack");
        chk("empty_unstall", int'(in_stall), 0);
        chk("empty_data", int'(in_data), 8'h3C);
        tick();
        id_ex_input_en = 1'b0;
        chk("empty_popped", int'(fifo_count), 0);
        in_strobe = 1'b0;
        wait_ack(1'b0, 10, "empty_ack_fall");

        // Ten bytes with interleaved pops across pointer wrap
        for (int i = 0; i < 10; i++) begin
            send_byte(DATA_W'(8'h60 + i));
            if (i >= 2) pop_check(DATA_W'(8'h60 + i - 2), "wrap_order");
        end
        pop_check(8'h68, "wrap_tail0");
        pop_check(8'h69, "wrap_tail1");

        // Held strobe: one capture, ack falls SYNC_STAGES edges after release
        in_port   = 8'h9E;
        in_strobe = 1'b1;
        repeat (20) tick();
        chk("held_cnt", int'(fifo_count), 1);
        chk("held_ack", int'(in_ack), 1);
        in_strobe = 1'b0;
        tick(); chk("held_fall_e0", int'(in_ack), 1);
        tick(); chk("held_fall_e1", int'(in_ack), 1);
        tick(); chk("held_fall_e2", int'(in_ack), 0);
        pop_check(8'h9E, "held_data");
        tick();
        chk("held_cnt0", int'(fifo_count), 0);

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
